// File: rtl/cmd_framer.sv
// Four-byte command framer (cmd, hi, lo, chk) with checksum and inter-byte timeout,
// plus a single-byte response transmitter handshake toward a UART.
module cmd_framer #(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   input  logic        tx_done,
   output logic        trmt,
   output logic [7:0]  tx_data,
   output logic        cmd_rdy,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   input  logic        clr_cmd_rdy,
   output logic        frm_err,
   input  logic        send_resp,
   input  logic [7:0]  resp,
   output logic        tx_busy,
   output logic        resp_sent
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO, WAIT_CHK} frm_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;

   frm_state_t    frm_state_q, frm_state_d;
   logic [CW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    cmd_byte_q, cmd_byte_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [15:0]   data_q, data_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          frm_err_q, frm_err_d;
   logic          rdy_set, rdy_clr;
   logic [7:0]    sum;

   tx_state_t     tx_state_q, tx_state_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          first_q, first_d;
   logic          resp_sent_q, resp_sent_d;

   assign clr_rx_rdy = rx_rdy & rst_n;
   assign sum        = cmd_byte_q + hi_q + lo_q + rx_data;

   // Frame FSM: capture bytes, validate checksum, police the inter-byte gap.
   always_comb begin
      frm_state_d = frm_state_q;
      to_cnt_d    = to_cnt_q;
      cmd_byte_d  = cmd_byte_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      frm_err_d   = 1'b0;
      rdy_set     = 1'b0;
      rdy_clr     = clr_cmd_rdy;

      if (frm_state_q == WAIT_CMD) begin
         to_cnt_d = '0;
         if (rx_rdy) begin
            cmd_byte_d  = rx_data;
            rdy_clr     = 1'b1;
            frm_state_d = WAIT_HI;
         end
      end else if (rx_rdy) begin
         to_cnt_d = '0;
         case (frm_state_q)
            WAIT_HI: begin
               hi_d        = rx_data;
               frm_state_d = WAIT_LO;
            end
            WAIT_LO: begin
               lo_d        = rx_data;
               frm_state_d = WAIT_CHK;
            end
            default: begin
               if (sum == 8'hFF) begin
                  cmd_d   = cmd_byte_q;
                  data_d  = {hi_q, lo_q};
                  rdy_set = 1'b1;
               end else begin
                  frm_err_d = 1'b1;
               end
               frm_state_d = WAIT_CMD;
            end
         endcase
      end else if (to_cnt_q == TO_MAX) begin
         frm_err_d   = 1'b1;
         to_cnt_d    = '0;
         frm_state_d = WAIT_CMD;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      // A completing frame wins over any clear in the same cycle.
      if (rdy_set)      cmd_rdy_d = 1'b1;
      else if (rdy_clr) cmd_rdy_d = 1'b0;
      else              cmd_rdy_d = cmd_rdy_q;
   end

   // Response FSM; the first TX_WAIT cycle ignores a tx_done the UART has not yet dropped.
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_data_d   = tx_data_q;
      first_d     = first_q;
      resp_sent_d = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (send_resp) begin
               tx_data_d  = resp;
               tx_state_d = TX_LOAD;
            end
         end
         TX_LOAD: begin
            first_d    = 1'b1;
            tx_state_d = TX_WAIT;
         end
         default: begin
            if (first_q) begin
               first_d = 1'b0;
            end else if (tx_done) begin
               resp_sent_d = 1'b1;
               tx_state_d  = TX_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frm_state_q <= WAIT_CMD;
         to_cnt_q    <= '0;
         cmd_byte_q  <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cmd_q       <= '0;
         data_q      <= '0;
         cmd_rdy_q   <= 1'b0;
         frm_err_q   <= 1'b0;
         tx_state_q  <= TX_IDLE;
         tx_data_q   <= '0;
         first_q     <= 1'b0;
         resp_sent_q <= 1'b0;
      end else begin
         frm_state_q <= frm_state_d;
         to_cnt_q    <= to_cnt_d;
         cmd_byte_q  <= cmd_byte_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         cmd_rdy_q   <= cmd_rdy_d;
         frm_err_q   <= frm_err_d;
         tx_state_q  <= tx_state_d;
         tx_data_q   <= tx_data_d;
         first_q     <= first_d;
         resp_sent_q <= resp_sent_d;
      end
   end

   assign cmd       = cmd_q;
   assign data      = data_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign frm_err   = frm_err_q;
   assign tx_data   = tx_data_q;
   assign trmt      = (tx_state_q == TX_LOAD);
   assign tx_busy   = (tx_state_q != TX_IDLE);
   assign resp_sent = resp_sent_q;

endmodule
